// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - valid/ready pipeline stage register with 2-entry skid buffer
// and hazard-classification flags over every held entry.
module pipe_skid_reg #(
  parameter int PAYLOAD_WIDTH  = 96,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int CLASS_WIDTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_en,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PAYLOAD_WIDTH-1:0]  in_payload,
  input  logic                      in_gpr_we_n,
  input  logic [GPR_ADDR_WIDTH-1:0] in_dst_addr,
  input  logic [CLASS_WIDTH-1:0]    in_class,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PAYLOAD_WIDTH-1:0]  out_payload,
  output logic                      out_gpr_we_n,
  output logic [GPR_ADDR_WIDTH-1:0] out_dst_addr,
  output logic [CLASS_WIDTH-1:0]    out_class,
  output logic [1:0]                occupancy,
  output logic                      load_pending,
  output logic                      alu2gpr_pending,
  output logic                      csr2gpr_pending
);

  localparam int ENTRY_WIDTH = PAYLOAD_WIDTH + 1 + GPR_ADDR_WIDTH + CLASS_WIDTH;
  localparam int WE_BIT      = GPR_ADDR_WIDTH + CLASS_WIDTH;
  localparam logic [ENTRY_WIDTH-1:0] ENTRY_CLEAR =
    {{PAYLOAD_WIDTH{1'b0}}, 1'b1, {GPR_ADDR_WIDTH{1'b0}}, {CLASS_WIDTH{1'b0}}};

  localparam logic [CLASS_WIDTH-1:0] CLS_ALU  = CLASS_WIDTH'(1);
  localparam logic [CLASS_WIDTH-1:0] CLS_LOAD = CLASS_WIDTH'(2);
  localparam logic [CLASS_WIDTH-1:0] CLS_CSR  = CLASS_WIDTH'(3);

  logic                   main_valid, skid_valid;
  logic [ENTRY_WIDTH-1:0] main_entry, skid_entry;
  logic [ENTRY_WIDTH-1:0] in_entry;
  logic                   in_fire, out_fire;

  assign in_entry = {in_payload, in_gpr_we_n, in_dst_addr, in_class};

  // Upstream ready comes only from registered state, so it never chains to out_ready.
  assign in_ready = cpu_en && !skid_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid && out_ready && cpu_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_entry <= ENTRY_CLEAR;
      skid_entry <= ENTRY_CLEAR;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_entry <= ENTRY_CLEAR;
      skid_entry <= ENTRY_CLEAR;
    end else if (cpu_en) begin
      if (!main_valid) begin
        if (in_fire) begin
          main_valid <= 1'b1;
          main_entry <= in_entry;
        end
      end else if (out_fire) begin
        if (skid_valid) begin
          main_entry <= skid_entry;
          skid_valid <= 1'b0;
        end else if (in_fire) begin
          main_entry <= in_entry;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (in_fire) begin
        skid_valid <= 1'b1;
        skid_entry <= in_entry;
      end
    end
  end

  function automatic logic writes_class(input logic valid,
                                        input logic [ENTRY_WIDTH-1:0] entry,
                                        input logic [CLASS_WIDTH-1:0] cls);
    return valid && !entry[WE_BIT] && (entry[CLASS_WIDTH-1:0] == cls);
  endfunction

  assign out_valid    = main_valid;
  assign out_payload  = main_entry[ENTRY_WIDTH-1 -: PAYLOAD_WIDTH];
  assign out_gpr_we_n = main_entry[WE_BIT] || !main_valid;
  assign out_dst_addr = main_entry[WE_BIT-1 -: GPR_ADDR_WIDTH];
  assign out_class    = main_entry[CLASS_WIDTH-1:0];
  assign occupancy    = {1'b0, main_valid} + {1'b0, skid_valid};

  assign load_pending    = writes_class(main_valid, main_entry, CLS_LOAD) ||
                           writes_class(skid_valid, skid_entry, CLS_LOAD);
  assign alu2gpr_pending = writes_class(main_valid, main_entry, CLS_ALU) ||
                           writes_class(skid_valid, skid_entry, CLS_ALU);
  assign csr2gpr_pending = writes_class(main_valid, main_entry, CLS_CSR) ||
                           writes_class(skid_valid, skid_entry, CLS_CSR);

endmodule
